instr_queue: RTL and testbench
==============================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 The block SHALL have parameter IW, default 8, giving the instruction width in bits.
REQ-002 The block SHALL have parameter IMM_W, default 4, giving the immediate field width, taken from instruction bits [IMM_W-1:0], with IMM_W < IW.
REQ-003 The block SHALL have parameter DW, default 8, giving the immediate output width, with DW >= IMM_W.
REQ-004 The block SHALL have parameter IMM_SIGNED, default 0: 0 selects zero-extension of the immediate, 1 selects sign-extension.
REQ-005 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; it SHALL be a power of 2 and >= 2.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 RST  input  1  reset, synchronous, active-high.
REQ-008 flush  input  1  discards all queued instructions (branch or restart).
REQ-009 in_valid  input  1  fetch side presents an instruction.
REQ-010 in_data  input  IW  instruction from memory.
REQ-011 in_ready  output  1  queue can accept an instruction this cycle.
REQ-012 out_valid  output  1  ir_out holds a valid instruction.
REQ-013 out_ready  input  1  controller consumes the current instruction this cycle.
REQ-014 ir_out  output  IW  head instruction, to the controller.
REQ-015 immediate  output  DW  extended immediate of ir_out.
REQ-016 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-017 Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready && !flush.
REQ-018 in_ready SHALL be (count < DEPTH) && !RST; when the queue is full and a pop happens in the same cycle, in_ready SHALL still be 0 and the push SHALL NOT occur.
REQ-019 out_valid SHALL be (count != 0).
REQ-020 ir_out SHALL be the oldest entry when out_valid=1 and all-zero when out_valid=0; it is a combinational read of the head entry, so it changes in the cycle after a pop with no bubble.
REQ-021 immediate SHALL be ir_out[IMM_W-1:0], zero- or sign-extended to DW per IMM_SIGNED; it SHALL be 0 when out_valid=0.
REQ-022 Latency: an instruction pushed at edge N into an empty queue SHALL appear on ir_out with out_valid=1 after edge N, in cycle N+1.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH: count SHALL be unchanged and both pointers SHALL advance.
REQ-024 Push and pop with count=0: the pop is not legal (out_valid=0), only the push SHALL take effect, and count SHALL become 1.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without special handling.
REQ-026 flush=1 SHALL set count, rd_ptr and wr_ptr to 0 at the next edge, ignoring any push or pop in that cycle; entry contents need not be cleared.
REQ-027 Order SHALL be strictly FIFO; no entry is overwritten before it is popped.

Reset
REQ-028 RST=1 at a rising edge SHALL set count=0, rd_ptr=0 and wr_ptr=0, giving out_valid=0, ir_out=0 and immediate=0.
REQ-029 RST SHALL take priority over flush, push and pop; reset in mid-operation SHALL discard all queued entries.
REQ-030 in_ready SHALL be 0 while RST=1 and become 1 in the first cycle after RST deasserts.

Structure
REQ-031 A shared package SHALL hold the default constants IW=8, IMM_W=4 and DW=8, and the immediate-extension helper function.
REQ-032 A single sub-module, imm_ext, SHALL implement the zero/sign extension from IMM_W to DW; the queue storage SHALL be flops with no RAM macro.

Verification
REQ-033 Reset then push 0xA5 -> in the next cycle out_valid=1, ir_out=0xA5, immediate=0x05 (IMM_SIGNED=0), count=1.
REQ-034 With IMM_SIGNED=1, push 0x3C -> immediate=0xFC; push 0x37 -> immediate=0x07.
REQ-035 Fill 4 entries (0x11, 0x22, 0x33, 0x44) with out_ready=0 -> in_ready=0 and count=4; a fifth push of 0x55 is refused; pops return 0x11 to 0x44 in order.
REQ-036 Sustained push and pop with count=2 for 10 cycles across pointer wrap -> count stays 2 and the output sequence equals the input sequence delayed by 2.
REQ-037 flush with count=3 and push 0x66 in the same cycle -> next cycle count=0, out_valid=0, ir_out=0, and 0x66 is never output.
REQ-038 RST asserted with count=2 during a push -> next cycle count=0 and out_valid=0; in_ready returns to 1 one cycle after RST drops.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared constants and immediate-extension helper for the instruction queue.
package instr_queue_pkg;

    localparam int IQ_IW    = 8;
    localparam int IQ_IMM_W = 4;
    localparam int IQ_DW    = 8;
    localparam int IQ_XW    = 32;

    // Widths are runtime arguments so one helper serves every instance.
    function automatic logic [IQ_XW-1:0] imm_extend(
        input logic [IQ_XW-1:0] raw,
        input int               imm_w,
        input bit               sgn
    );
        logic [IQ_XW-1:0] res;
        res = '0;
        for (int i = 0; i < IQ_XW; i++) begin
            if (i < imm_w)
                res[i] = raw[i];
            else
                res[i] = sgn & raw[imm_w-1];
        end
        return res;
    endfunction

endpackage

// File: rtl/instr_queue_imm_ext.sv
// Zero/sign extension of the instruction immediate field.
module imm_ext
    import instr_queue_pkg::*;
#(
    parameter int IMM_W      = IQ_IMM_W,
    parameter int DW         = IQ_DW,
    parameter bit IMM_SIGNED = 1'b0
) (
    input  logic [IMM_W-1:0] imm_i,
    output logic [DW-1:0]    imm_o
);

    logic [IQ_XW-1:0] raw;
    logic [IQ_XW-1:0] ext;

    always_comb begin
        raw   = IQ_XW'(imm_i);
        ext   = imm_extend(raw, IMM_W, IMM_SIGNED);
        imm_o = DW'(ext);
    end

endmodule

// File: rtl/instr_queue.sv
// Flop-based instruction FIFO between fetch and the controller.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int IW         = IQ_IW,
    parameter int IMM_W      = IQ_IMM_W,
    parameter int DW         = IQ_DW,
    parameter bit IMM_SIGNED = 1'b0,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [IW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] ir_out,
    output logic [DW-1:0] immediate,
    output logic [CW-1:0] count
);

    logic [IW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    assign in_ready  = (cnt_q < CW'(DEPTH)) && !RST;
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign ir_out    = out_valid ? mem_q[rd_q] : '0;
    assign count     = cnt_q;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        unique case (1'b1)
            push && !pop: cnt_d = cnt_q + 1'b1;
            pop && !push: cnt_d = cnt_q - 1'b1;
            default:      cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST || flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload needs no reset; occupancy alone decides visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= in_data;
    end

    imm_ext #(
        .IMM_W      (IMM_W),
        .DW         (DW),
        .IMM_SIGNED (IMM_SIGNED)
    ) u_imm_ext (
        .imm_i (ir_out[IMM_W-1:0]),
        .imm_o (immediate)
    );

endmodule

// File: tb/tb_instr_queue.sv
// Randomized and directed bench for instr_queue against a queue model.
module tb_instr_queue;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;

    logic       rdy0, vld0, rdy1, vld1;
    logic [7:0] ir0, ir1, imm0, imm1;
    logic [2:0] cnt0, cnt1;

    int vecs = 0;
    int errs = 0;

    logic [7:0] mq[$];

    always #5 clk = ~clk;

    instr_queue u_dut_z (
        .clk       (clk),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy0),
        .out_valid (vld0),
        .out_ready (out_ready),
        .ir_out    (ir0),
        .immediate (imm0),
        .count     (cnt0)
    );

    instr_queue #(.IMM_SIGNED(1'b1)) u_dut_s (
        .clk       (clk),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy1),
        .out_valid (vld1),
        .out_ready (out_ready),
        .ir_out    (ir1),
        .immediate (imm1),
        .count     (cnt1)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        logic [7:0] head;
        int         n;
        int         lo;
        n    = mq.size();
        head = (n != 0) ? mq[0] : 8'h00;
        lo   = int'(head) % 16;
        expect_eq("count_z", 32'(cnt0), 32'(n));
        expect_eq("count_s", 32'(cnt1), 32'(n));
        expect_eq("valid", 32'(vld0), 32'(n != 0));
        expect_eq("ready", 32'(rdy0), 32'(n < 4 && !RST));
        expect_eq("ready_s", 32'(rdy1), 32'(n < 4 && !RST));
        expect_eq("ir_z", 32'(ir0), 32'(head));
        expect_eq("ir_s", 32'(ir1), 32'(head));
        expect_eq("imm_z", 32'(imm0), 32'(lo));
        expect_eq("imm_s", 32'(imm1), 32'((lo >= 8) ? lo + 240 : lo));
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [7:0] d, input logic ordy);
        bit do_push, do_pop;
        RST = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        check_state();
        do_push = iv && (mq.size() < 4) && !r && !f;
        do_pop  = ordy && (mq.size() != 0) && !r && !f;
        @(posedge clk);
        if (r || f) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        @(posedge clk);
        @(negedge clk);
        step(1, 0, 0, 8'h00, 0);

        step(0, 0, 1, 8'hA5, 0);
        expect_eq("a5_ir", 32'(ir0), 32'h0000_00A5);
        expect_eq("a5_imm", 32'(imm0), 32'h0000_0005);
        step(0, 0, 0, 8'h00, 1);

        step(0, 0, 1, 8'h3C, 0);
        expect_eq("3c_imm_s", 32'(imm1), 32'h0000_00FC);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'h37, 0);
        expect_eq("37_imm_s", 32'(imm1), 32'h0000_0007);
        step(0, 0, 0, 8'h00, 1);

        for (int i = 0; i < 4; i++) step(0, 0, 1, fill[i], 0);
        expect_eq("full_ready", 32'(rdy0), 32'h0);
        step(0, 0, 1, 8'h55, 1);
        step(0, 0, 1, 8'h55, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 1);

        step(0, 0, 1, 8'h01, 0);
        step(0, 0, 1, 8'h02, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'(8'h80 + i * 7), 1);
        expect_eq("sust_cnt", 32'(cnt0), 32'h2);

        step(0, 0, 1, 8'h77, 0);
        step(0, 1, 1, 8'h66, 1);
        expect_eq("flush_vld", 32'(vld0), 32'h0);
        step(0, 0, 0, 8'h00, 1);

        step(0, 0, 1, 8'hC1, 0);
        step(0, 0, 1, 8'hC2, 0);
        step(1, 0, 1, 8'hC3, 1);
        expect_eq("rst_cnt", 32'(cnt0), 32'h0);
        step(0, 0, 0, 8'h00, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
                 1'($urandom), 8'($urandom), 1'($urandom));
        end
        step(0, 0, 0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
